// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - AXI4-Lite master driven by a single-beat command/response interface
//
// Converts one command at a time into an AXI-Lite write (AW+W, then B) or
// read (AR, then R) and returns the slave status on the response port.
// Exactly one transaction is outstanding; all outputs are registered.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn    clock, synchronous active-low reset
//   cmd_*                        command in (valid/ready, write flag, addr, wdata)
//   rsp_*                        response out (valid/ready, rdata, resp, write echo)
//   err_cnt                      saturating count of non-OKAY responses
//   m_axi_aw*/w*/b*/ar*/r*       AXI4-Lite master channels
//
// Optional feature: define AXIL_MST_TIMEOUT_EN to abort a transaction that
// waits TIMEOUT_CYCLES cycles in a bus-wait state; it completes with resp 2'b10.

module axil_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_write,
    output logic [15:0] err_cnt,

    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic [31:0] m_axi_wdata,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [1:0]  m_axi_bresp,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_araddr,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic [1:0]  rsp_resp_q;
    logic        rsp_write_q;
    logic [15:0] err_cnt_q;
    logic        awvalid_q;
    logic [31:0] awaddr_q;
    logic        wvalid_q;
    logic [31:0] wdata_q;
    logic        bready_q;
    logic        arvalid_q;
    logic [31:0] araddr_q;
    logic        rready_q;

    logic        cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
    logic        wr_req_done;
    logic        progress_d;
    logic [15:0] err_cnt_inc_d;

    assign cmd_hs = cmd_valid && cmd_ready_q;
    assign aw_hs  = awvalid_q && m_axi_awready;
    assign w_hs   = wvalid_q && m_axi_wready;
    assign b_hs   = bready_q && m_axi_bvalid;
    assign ar_hs  = arvalid_q && m_axi_arready;
    assign r_hs   = rready_q && m_axi_rvalid;
    assign rsp_hs = rsp_valid_q && rsp_ready;

    // AW and W complete independently; the write request phase ends once
    // neither is still pending after this edge.
    assign wr_req_done = (!awvalid_q || aw_hs) && (!wvalid_q || w_hs);

    // Saturating increment, applied only when a non-OKAY status enters RSP.
    assign err_cnt_inc_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

    // The bus-wait state finishes its handshake on this edge.
    always_comb begin
        progress_d = 1'b0;
        case (state_q)
            WR_REQ:  progress_d = wr_req_done;
            WR_RESP: progress_d = b_hs;
            RD_REQ:  progress_d = ar_hs;
            RD_DATA: progress_d = r_hs;
            default: progress_d = 1'b0;
        endcase
    end

`ifdef AXIL_MST_TIMEOUT_EN
    logic [15:0] wait_cnt_q;
    logic        in_wait;
    logic        timeout_hit;

    assign in_wait = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                     (state_q == RD_REQ) || (state_q == RD_DATA);

    // Counter is zero in the first cycle of every wait state, so the limit is
    // reached on the edge closing the TIMEOUT_CYCLES-th cycle of waiting.
    assign timeout_hit = in_wait && (wait_cnt_q == TO_LIMIT - 16'd1);

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn || !in_wait || progress_d || timeout_hit) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end
`else
    logic timeout_hit;
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TO_LIMIT;
`endif

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_write_q <= 1'b0;
            err_cnt_q   <= '0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            rready_q    <= 1'b0;
        end else if (timeout_hit && !progress_d) begin
            // A handshake landing on the limit edge takes precedence (progress_d).
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_resp_q  <= 2'b10;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            err_cnt_q   <= err_cnt_inc_d;
            state_q     <= RSP;
        end else begin
            case (state_q)
                IDLE: begin
                    // Ready rises one cycle after reset release or response hand-off.
                    cmd_ready_q <= 1'b1;
                    if (cmd_hs) begin
                        cmd_ready_q <= 1'b0;
                        rsp_write_q <= cmd_write;
                        awaddr_q    <= cmd_addr;
                        araddr_q    <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    if (wr_req_done) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= m_axi_bresp;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        if (m_axi_bresp != 2'b00) err_cnt_q <= err_cnt_inc_d;
                        state_q     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        rready_q    <= 1'b0;
                        rsp_resp_q  <= m_axi_rresp;
                        // Error reads never leak slave data to the client.
                        rsp_rdata_q <= (m_axi_rresp == 2'b00) ? m_axi_rdata : 32'd0;
                        rsp_valid_q <= 1'b1;
                        if (m_axi_rresp != 2'b00) err_cnt_q <= err_cnt_inc_d;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_write     = rsp_write_q;
    assign err_cnt       = err_cnt_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_rready  = rready_q;

endmodule
